// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types and constants for the iterative multiply/divide
//            unit: operation and state encodings, default operand width and
//            the R-type funct codes the control FSM decodes into an op.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int unsigned c_width = 32;

  // R-type funct codes for the four multiply/divide instructions
  localparam logic [5:0] c_funct_mult  = 6'h18;
  localparam logic [5:0] c_funct_multu = 6'h19;
  localparam logic [5:0] c_funct_div   = 6'h1A;
  localparam logic [5:0] c_funct_divu  = 6'h1B;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // The low two funct bits already match the op_t encoding. A funct outside
  // 0x18..0x1B maps to MULT; the caller only raises start for valid codes.
  function automatic op_t funct_to_op(input logic [5:0] funct);
    if (funct[5:2] == c_funct_mult[5:2]) begin
      return op_t'(funct[1:0]);
    end
    return MULT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer_if
// Purpose  : Start/done handshake and result bus between the control FSM
//            (master) and the multiply/divide sequencer (slave).
// Signals  : start, op, a_in, b_in        master -> slave
//            busy, done, div_zero, hi, lo  slave  -> master
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_sequencer_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = c_width
);

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, div_zero, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
//            Signed operations run on operand magnitudes and fix the signs
//            up at the end; multiply is shift-add (LSB first), divide is
//            restoring (MSB first). Both share one 2*WIDTH accumulator.
// Ports    : Clk    - clock, rising edge
//            Reset  - asynchronous, active-high
//            bus    - slave modport: start/op/a_in/b_in in,
//                     busy/done/div_zero/hi/lo out
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = c_width,
  parameter int CNT_W = 6
) (
  input logic               Clk,
  input logic               Reset,
  muldiv_sequencer_if.slave bus
);

  state_t             r_state;
  state_t             w_next;
  op_t                r_op;
  logic [WIDTH-1:0]   r_ma;        // raw a, then |a| (multiplicand)
  logic [WIDTH-1:0]   r_mb;        // raw b, then |b| (divisor)
  logic [2*WIDTH-1:0] r_acc;       // mult: {partial, multiplier}; div: {rem, quot}
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_dz_pend;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_busy;
  logic               w_done;
  logic               w_div_zero;

  // ---------------------------------------------------------------- decode
  logic             w_is_div;
  logic             w_signed_op;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  assign w_is_div    = (r_op == DIV) || (r_op == DIVU);
  assign w_signed_op = (r_op == MULT) || (r_op == DIV);
  assign w_sign_a    = w_signed_op & r_ma[WIDTH-1];
  assign w_sign_b    = w_signed_op & r_mb[WIDTH-1];
  // |-2^(WIDTH-1)| wraps to itself, which is the right unsigned magnitude
  assign w_abs_a     = w_sign_a ? -r_ma : r_ma;
  assign w_abs_b     = w_sign_b ? -r_mb : r_mb;

  // ------------------------------------------------------- multiply step
  logic [WIDTH:0] w_mul_sum;

  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_acc[0] ? r_ma : {WIDTH{1'b0}})};

  // --------------------------------------------------------- divide step
  // The partial remainder is always below the divisor, so after the shift
  // it fits in WIDTH+1 bits and the top bit of the WIDTH+1 bit difference
  // is exactly the borrow of the trial subtract.
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_rem;

  assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_mb};
  assign w_ge      = ~w_trial[WIDTH];
  assign w_div_rem = w_ge ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  // ----------------------------------------------------------- sign fix
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quot = r_acc[WIDTH-1:0];
  assign w_rem  = r_acc[2*WIDTH-1:WIDTH];

  // ------------------------------------------------------ state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ------------------------------------------- next state and FSM outputs
  always_comb begin
    w_next     = r_state;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_div_zero = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = PREP;
        end
      end
      PREP: begin
        w_busy = 1'b1;
        if (w_is_div && (r_mb == {WIDTH{1'b0}})) begin
          w_next = DONE;
        end else begin
          w_next = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_next = FIX;
        end
      end
      FIX: begin
        w_busy = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        w_done     = 1'b1;
        w_div_zero = r_dz_pend;
        w_next     = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_op      <= MULT;
      r_ma      <= '0;
      r_mb      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz_pend <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op      <= bus.op;
            r_ma      <= bus.a_in;
            r_mb      <= bus.b_in;
            r_dz_pend <= 1'b0;
          end
        end
        PREP: begin
          r_ma      <= w_abs_a;
          r_mb      <= w_abs_b;
          r_neg_res <= w_sign_a ^ w_sign_b;
          r_neg_rem <= w_sign_a;
          r_dz_pend <= w_is_div && (r_mb == {WIDTH{1'b0}});
          r_cnt     <= CNT_W'(WIDTH);
          // dividend or multiplier enters the low half of the accumulator
          r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
        end
        RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_is_div) begin
            r_acc <= {w_div_rem, r_acc[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (w_is_div) begin
            r_lo <= r_neg_res ? -w_quot : w_quot;
            r_hi <= r_neg_rem ? -w_rem : w_rem;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.div_zero = w_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Self-checking bench for muldiv_sequencer. Directed cases from the
//            operation table plus randomized operations compared against an
//            arithmetic reference model; checks latency, busy, done/div_zero
//            pulses, start filtering and asynchronous reset abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic Clk;
  logic Reset;
  int   errors;
  int   checks;

  // model's view of HI/LO, used for divide-by-zero and stability checks
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural operands.
  function automatic void model(input op_t op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] h,
                                output logic [W-1:0] l, output logic dz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    h  = m_hi;
    l  = m_lo;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MULT: begin
        p = 64'(sa * sb);
        h = p[63:32];
        l = p[31:0];
      end
      MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        h = p[63:32];
        l = p[31:0];
      end
      DIV: begin
        if (b == 0) begin
          dz = 1'b1;
        end else begin
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          dz = 1'b1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  // Issue one operation starting at the current sample point, follow it to
  // its done pulse and check everything about it. With hold_start set,
  // start is raised during the DONE cycle (must be ignored) and left high.
  task automatic run_check(input string name, input op_t op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                           input logic exp_dz, input logic hold_start);
    int   k;
    int   exp_k;
    logic stable_ok;
    exp_k = exp_dz ? 1 : W + 2;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a_in  = a;
    bus.b_in  = b;
    tick();
    // operand changes after acceptance must not matter
    bus.start = 1'b0;
    bus.op    = op_t'($urandom_range(0, 3));
    bus.a_in  = $urandom;
    bus.b_in  = $urandom;
    k = 0;
    stable_ok = 1'b1;
    do begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 ||
          bus.hi !== m_hi || bus.lo !== m_lo) stable_ok = 1'b0;
      tick();
      k++;
    end while (bus.done !== 1'b1 && k < 100);

    checks++;
    if (k !== exp_k) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, k, exp_k);
    end
    checks++;
    if (stable_ok !== 1'b1) begin
      errors++;
      $display("FAIL %s busy/hold: busy low or hi/lo moved before done (got %b, expected 1)", name, stable_ok);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b, expected 0", name, bus.busy);
    end
    checks++;
    if (bus.hi !== exp_hi) begin
      errors++;
      $display("FAIL %s hi: got %h, expected %h", name, bus.hi, exp_hi);
    end
    checks++;
    if (bus.lo !== exp_lo) begin
      errors++;
      $display("FAIL %s lo: got %h, expected %h", name, bus.lo, exp_lo);
    end
    checks++;
    if (bus.div_zero !== exp_dz) begin
      errors++;
      $display("FAIL %s div_zero: got %b, expected %b", name, bus.div_zero, exp_dz);
    end
    m_hi = exp_hi;
    m_lo = exp_lo;
    if (hold_start) begin
      bus.start = 1'b1;
      bus.op    = op_t'($urandom_range(0, 3));
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.div_zero !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b div_zero=%b busy=%b, expected 0 0 0",
               name, bus.done, bus.div_zero, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.op    = MULT;
    bus.a_in  = '0;
    bus.b_in  = '0;
    Reset     = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000 || bus.hi !== '0 || bus.lo !== '0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b dz=%b hi=%h lo=%h, expected all zero",
               bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
    end
  endtask

  task automatic test_directed();
    run_check("mult_neg3x7", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
    run_check("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    run_check("div_neg7_2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_check("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    run_check("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
  endtask

  task automatic test_div_zero();
    // 0x55555556 * 0x33333333 = 0x11111111_22222222
    run_check("preload", MULTU, 32'h55555556, 32'h33333333, 32'h11111111, 32'h22222222, 1'b0, 1'b0);
    run_check("divu_zero", DIVU, 32'd5, 32'd0, 32'h11111111, 32'h22222222, 1'b1, 1'b0);
    run_check("div_zero", DIV, 32'hFFFFFFF0, 32'd0, 32'h11111111, 32'h22222222, 1'b1, 1'b0);
  endtask

  task automatic test_ignored_start();
    logic [W-1:0] eh, el;
    logic         edz;
    int           k;
    int           extra;
    model(MULT, 32'h12345678, 32'hFEDCBA98, eh, el, edz);
    bus.start = 1'b1;
    bus.op    = MULT;
    bus.a_in  = 32'h12345678;
    bus.b_in  = 32'hFEDCBA98;
    tick();
    bus.start = 1'b0;
    k = 0;
    while (bus.done !== 1'b1 && k < 100) begin
      tick();
      k++;
      if (k == 9) begin
        bus.start = 1'b1;
        bus.op    = DIVU;
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
    checks++;
    if (k !== W + 2) begin
      errors++;
      $display("FAIL ignored_start latency: got %0d, expected %0d", k, W + 2);
    end
    checks++;
    if (bus.hi !== eh || bus.lo !== el) begin
      errors++;
      $display("FAIL ignored_start result: got %h_%h, expected %h_%h", bus.hi, bus.lo, eh, el);
    end
    m_hi  = eh;
    m_lo  = el;
    extra = 0;
    repeat (45) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignored_start queued: got %0d busy/done cycles, expected 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int extra;
    bus.start = 1'b1;
    bus.op    = MULT;
    bus.a_in  = 32'h00001234;
    bus.b_in  = 32'hFFFF0001;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h, expected 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    tick();
    Reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    extra = 0;
    repeat (45) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL reset_abort_no_done: got %0d busy/done cycles, expected 0", extra);
    end
    run_check("after_reset", MULT, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 1'b0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h00000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      4:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    op_t          op;
    logic [W-1:0] a, b, eh, el;
    logic         edz;
    for (int i = 0; i < 40; i++) begin
      op = op_t'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      model(op, a, b, eh, el, edz);
      run_check($sformatf("rand%0d_%s", i, op.name()), op, a, b, eh, el, edz,
                1'($urandom_range(0, 1)));
    end
    bus.start = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Reset  = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_div_zero();
    test_ignored_start();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
